demo_scene_sequencer: RTL and testbench

Frame-level scheduler for the demo graphics engine. It detects frame boundaries on `v_sync` and owns the animation counter the engine's layers scroll by. It steps a fade-in / hold / fade-out state machine and rotates through scenes. All outputs are registered and change only on a frame boundary, so the pixel datapath never sees a mid-frame update.

---
 rtl/demo_scene_sequencer.sv | 122 ++++++++++++
 tb/tb_demo_scene_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/demo_scene_sequencer.sv
// Frame-level scene scheduler: detects v_sync edges, advances the animation
// counter and steps a fade-in / hold / fade-out sequence across scenes.
module demo_scene_sequencer #(
    parameter int HOLD_FRAMES      = 240,
    parameter int FADE_STEP_FRAMES = 8,
    parameter int NUM_SCENES       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       v_sync,
    input  logic       pause,
    input  logic       skip,
    output logic [9:0] anim_ctr,
    output logic [1:0] scene,
    output logic [1:0] fade,
    output logic       frame_tick,
    output logic       scene_change
);

    typedef enum logic [1:0] {FADE_IN, HOLD, FADE_OUT} state_t;

    localparam logic [7:0] FADE_LAST  = 8'(FADE_STEP_FRAMES - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
    localparam logic [1:0] SCENE_LAST = 2'(NUM_SCENES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       vs_q, sk_q;
    logic       skip_pending, skp_d;
    logic [9:0] anim_d;
    logic [1:0] scene_d, fade_d;
    logic       sc_d;
    logic       tick, skip_rise;

    assign tick      = v_sync & ~vs_q;
    assign skip_rise = skip & ~sk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q         <= 1'b1;
            sk_q         <= 1'b0;
            skip_pending <= 1'b0;
            state_q      <= FADE_IN;
            cnt_q        <= '0;
            anim_ctr     <= '0;
            scene        <= '0;
            fade         <= '0;
            frame_tick   <= 1'b0;
            scene_change <= 1'b0;
        end else begin
            vs_q         <= v_sync;
            sk_q         <= skip;
            skip_pending <= skp_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            anim_ctr     <= anim_d;
            scene        <= scene_d;
            fade         <= fade_d;
            frame_tick   <= tick;
            scene_change <= sc_d;
        end
    end

    // A skip edge coinciding with a tick is kept for the next tick, since the
    // consumed flag is taken from the registered pending bit only.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        anim_d  = anim_ctr;
        scene_d = scene;
        fade_d  = fade;
        sc_d    = 1'b0;
        skp_d   = skip_pending | skip_rise;
        if (tick && !pause) begin
            anim_d = anim_ctr + 10'd1;
            if (skip_pending) skp_d = skip_rise;
            if (skip_pending && state_q != FADE_OUT) begin
                state_d = FADE_OUT;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    FADE_IN: begin
                        if (cnt_q == FADE_LAST) begin
                            cnt_d  = '0;
                            fade_d = fade + 2'd1;
                            if (fade_d == 2'd3) state_d = HOLD;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                    HOLD: begin
                        if (cnt_q == HOLD_LAST) begin
                            cnt_d   = '0;
                            state_d = FADE_OUT;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                    FADE_OUT: begin
                        if (cnt_q == FADE_LAST) begin
                            cnt_d  = '0;
                            // Skipping out of black leaves nothing to dim.
                            fade_d = (fade == 2'd0) ? 2'd0 : fade - 2'd1;
                            if (fade_d == 2'd0) begin
                                scene_d = (scene == SCENE_LAST) ? 2'd0 : scene + 2'd1;
                                sc_d    = 1'b1;
                                state_d = FADE_IN;
                            end
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                    default: begin
                        state_d = FADE_IN;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_demo_scene_sequencer.sv
// Scoreboard bench for demo_scene_sequencer: expected per-tick outputs are
// queued as v_sync pulses are driven and checked when frame_tick appears.
module tb_demo_scene_sequencer;

    localparam int FS = 2;
    localparam int HF = 4;
    localparam int NS = 3;
    localparam int P  = 6 * FS + HF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v_sync = 1'b0;
    logic       pause = 1'b0;
    logic       skip = 1'b0;
    logic [9:0] anim_ctr;
    logic [1:0] scene, fade;
    logic       frame_tick, scene_change;

    demo_scene_sequencer #(.HOLD_FRAMES(HF), .FADE_STEP_FRAMES(FS), .NUM_SCENES(NS)) dut (
        .clk(clk), .rst_n(rst_n), .v_sync(v_sync), .pause(pause), .skip(skip),
        .anim_ctr(anim_ctr), .scene(scene), .fade(fade),
        .frame_tick(frame_tick), .scene_change(scene_change)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] anim;
        logic [1:0] scene;
        logic [1:0] fade;
        logic       sc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   n = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Closed-form position within the scene cycle after nn unpaused ticks.
    function automatic exp_t model(input int nn, input bit paused);
        exp_t e;
        int   k;
        k       = nn % P;
        e.anim  = 10'(nn % 1024);
        e.scene = 2'((nn / P) % NS);
        if (k < 3 * FS)           e.fade = 2'(k / FS);
        else if (k < 3 * FS + HF) e.fade = 2'd3;
        else                      e.fade = 2'(3 - (k - 3 * FS - HF) / FS);
        e.sc = !paused && nn > 0 && k == 0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (frame_tick) begin
                if (q.size() == 0) chk("unexpected_tick", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    chk("anim_ctr", 32'(anim_ctr), 32'(e.anim));
                    chk("scene", 32'(scene), 32'(e.scene));
                    chk("fade", 32'(fade), 32'(e.fade));
                    chk("scene_change", 32'(scene_change), 32'(e.sc));
                end
            end else begin
                chk("sc_without_tick", 32'(scene_change), 32'd0);
            end
        end
    end

    task automatic pulse();
        @(negedge clk) v_sync = 1'b1;
        @(negedge clk) v_sync = 1'b0;
        @(negedge clk);
    endtask

    task automatic tick(input bit paused);
        pause = paused;
        if (!paused) n++;
        q.push_back(model(n, paused));
        pulse();
        pause = 1'b0;
    endtask

    task automatic push_exp(input int a, input int s, input int f, input bit c);
        exp_t e;
        e.anim = 10'(a); e.scene = 2'(s); e.fade = 2'(f); e.sc = c;
        q.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_anim"}, 32'(anim_ctr), 32'd0);
        chk({tag, "_scene"}, 32'(scene), 32'd0);
        chk({tag, "_fade"}, 32'(fade), 32'd0);
        chk({tag, "_tick"}, 32'(frame_tick), 32'd0);
        chk({tag, "_sc"}, 32'(scene_change), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; v_sync = 1'b0; pause = 1'b0; skip = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        n = 0;
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 20;
        while (q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk(tag, 32'(q.size()), 32'd0);
    endtask

    initial begin
        // Fade ramp, hold, fade-out and three scene wraps.
        do_reset();
        for (int i = 0; i < 48; i++) tick(1'b0);
        drain("drain_run48");

        // Pause over ticks 3..7.
        do_reset();
        for (int i = 1; i <= 12; i++) tick(i >= 3 && i <= 7);
        drain("drain_pause");

        // Skip raised during HOLD, acted on at tick 8.
        do_reset();
        for (int i = 0; i < 7; i++) tick(1'b0);
        @(negedge clk) skip = 1'b1;
        @(negedge clk) skip = 1'b0;
        push_exp(8, 0, 3, 0);  pulse();
        push_exp(9, 0, 3, 0);  pulse();
        push_exp(10, 0, 2, 0); pulse();
        push_exp(11, 0, 2, 0); pulse();
        push_exp(12, 0, 1, 0); pulse();
        push_exp(13, 0, 1, 0); pulse();
        push_exp(14, 1, 0, 1); pulse();
        push_exp(15, 1, 0, 0); pulse();
        drain("drain_skip");

        // Long v_sync gives one tick; then anim_ctr wraps at 1024 ticks.
        do_reset();
        n = 1;
        q.push_back(model(n, 1'b0));
        @(negedge clk) v_sync = 1'b1;
        repeat (100) @(negedge clk);
        v_sync = 1'b0;
        drain("drain_long_vsync");
        for (int i = 0; i < 1023; i++) tick(1'b0);
        drain("drain_wrap");
        chk("anim_wrapped", 32'(anim_ctr), 32'd0);

        // Reset mid-HOLD with v_sync high, then no tick until a fresh edge.
        do_reset();
        for (int i = 0; i < 7; i++) tick(1'b0);
        n++;
        q.push_back(model(n, 1'b0));
        @(negedge clk) v_sync = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        chk("queue_before_reset", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        v_sync = 1'b0;
        n = 0;
        tick(1'b0);
        drain("drain_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: observed no finish expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
